// File: rtl/bf16_round_pack_if.sv
// rtl/bf16_round_pack_if.sv - operand/result handshake bundle for the bf16 packer
interface bf16_round_pack_if #(
  parameter int NEXP = 8,
  parameter int NSIG = 7
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_sign;
  logic signed [NEXP+1:0] in_exp;
  logic [NSIG+3:0]        in_sig;
  logic [5:0]             in_flags;
  logic                   out_valid;
  logic                   out_ready;
  logic [NEXP+NSIG:0]     out_bf16;
  logic [3:0]             out_exc;

  // Upstream arithmetic unit / downstream consumer side
  modport master (
    output in_valid, in_sign, in_exp, in_sig, in_flags, out_ready,
    input  in_ready, out_valid, out_bf16, out_exc
  );

  // Packer side
  modport slave (
    input  in_valid, in_sign, in_exp, in_sig, in_flags, out_ready,
    output in_ready, out_valid, out_bf16, out_exc
  );
endinterface

// File: rtl/bf16_round_pack.sv
// rtl/bf16_round_pack.sv - normalise, denormalise, RNE-round and pack an unpacked result into bfloat16
module bf16_round_pack #(
  parameter int NEXP = 8,
  parameter int NSIG = 7
) (
  input logic              clk,
  input logic              rst,
  bf16_round_pack_if.slave bus
);
  localparam int W  = NSIG + 4;          // hidden + fraction + G,R,S
  localparam int EW = NEXP + 2;          // signed working exponent
  localparam int CW = $clog2(W + 1);

  // Class flag bit positions
  localparam int F_INF  = 5;
  localparam int F_SNAN = 4;
  localparam int F_QNAN = 3;
  localparam int F_ZERO = 2;
  localparam int F_SUB  = 1;
  localparam int F_NORM = 0;

  localparam logic signed [EW-1:0] EXP_ONE      = EW'(1);
  localparam logic signed [EW-1:0] EXP_MAX      = EW'((1 << NEXP) - 1);
  localparam logic [CW-1:0]        DENORM_LIMIT = CW'(W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_NORM,
    S_DENORM,
    S_ROUND,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic                   sign_q, sign_d;
  logic signed [EW-1:0]   exp_q, exp_d;
  logic [W-1:0]           sig_q, sig_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NEXP+NSIG:0]     out_bf16_q, out_bf16_d;
  logic [3:0]             out_exc_q, out_exc_d;

  logic [NSIG:0]          keep, keep_r;
  logic [NSIG+1:0]        keep_sum;
  logic                   g, rs, up, inexact;
  logic signed [EW-1:0]   exp_r;
  logic [W-1:0]           sig_sh;
  logic signed [EW-1:0]   exp_inc;
  logic [CW-1:0]          cnt_inc;
  logic                   unused_class;

  // SUBNORMAL/NORMAL both simply take the normalise path, so their bits carry no extra information
  assign unused_class = bus.in_flags[F_SUB] ^ bus.in_flags[F_NORM];

  // One right-shift step: the bit falling off the end is folded into the sticky bit
  assign sig_sh  = {1'b0, sig_q[W-1:2], sig_q[1] | sig_q[0]};
  assign exp_inc = exp_q + EXP_ONE;
  assign cnt_inc = cnt_q + CW'(1);

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_bf16  = out_bf16_q;
  assign bus.out_exc   = out_exc_q;

  // Round-to-nearest-even on the current significand, including mantissa carry-out renormalisation
  always_comb begin
    keep     = sig_q[W-1:3];
    g        = sig_q[2];
    rs       = sig_q[1] | sig_q[0];
    up       = g & (rs | keep[0]);
    inexact  = g | rs;
    keep_sum = {1'b0, keep} + {{(NSIG+1){1'b0}}, up};
    if (keep_sum[NSIG+1]) begin
      keep_r = {1'b1, {NSIG{1'b0}}};
      exp_r  = exp_q + EXP_ONE;
    end else begin
      keep_r = keep_sum[NSIG:0];
      exp_r  = exp_q;
    end
  end

  // Next-state and datapath updates for the IDLE/NORM/DENORM/ROUND/DONE sequence
  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    sig_d      = sig_q;
    cnt_d      = cnt_q;
    out_bf16_d = out_bf16_q;
    out_exc_d  = out_exc_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          sign_d = bus.in_sign;
          exp_d  = bus.in_exp;
          sig_d  = bus.in_sig;
          cnt_d  = '0;
          if (bus.in_flags[F_QNAN]) begin
            out_bf16_d = {bus.in_sign, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};
            out_exc_d  = 4'b0000;
            state_d    = S_DONE;
          end else if (bus.in_flags[F_SNAN]) begin
            out_bf16_d = {bus.in_sign, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};
            out_exc_d  = 4'b1000;
            state_d    = S_DONE;
          end else if (bus.in_flags[F_INF]) begin
            out_bf16_d = {bus.in_sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
            out_exc_d  = 4'b0000;
            state_d    = S_DONE;
          end else if (bus.in_flags[F_ZERO] || (bus.in_sig == '0)) begin
            out_bf16_d = {bus.in_sign, {(NEXP+NSIG){1'b0}}};
            out_exc_d  = 4'b0000;
            state_d    = S_DONE;
          end else begin
            state_d = S_NORM;
          end
        end
      end
      S_NORM: begin
        // Left shifting stops at exp==1 so a subnormal never drives the exponent below 1
        if (!sig_q[W-1] && (exp_q > EXP_ONE)) begin
          sig_d = sig_q << 1;
          exp_d = exp_q - EXP_ONE;
        end else if (exp_q < EXP_ONE) begin
          state_d = S_DENORM;
        end else begin
          state_d = S_ROUND;
        end
      end
      S_DENORM: begin
        sig_d = sig_sh;
        exp_d = exp_inc;
        cnt_d = cnt_inc;
        if (exp_inc == EXP_ONE) begin
          state_d = S_ROUND;
        end else if (cnt_inc == DENORM_LIMIT) begin
          // Everything has already collapsed into sticky; jump straight to the minimum exponent
          exp_d   = EXP_ONE;
          sig_d   = {{(W-1){1'b0}}, |sig_sh};
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        exp_d = exp_r;
        if (exp_r >= EXP_MAX) begin
          out_bf16_d = {sign_q, {NEXP{1'b1}}, {NSIG{1'b0}}};
          out_exc_d  = 4'b0101;
        end else if (!keep_r[NSIG]) begin
          out_bf16_d = {sign_q, {NEXP{1'b0}}, keep_r[NSIG-1:0]};
          out_exc_d  = {2'b00, inexact, inexact};
        end else begin
          out_bf16_d = {sign_q, exp_r[NEXP-1:0], keep_r[NSIG-1:0]};
          out_exc_d  = {3'b000, inexact};
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      sig_q      <= '0;
      cnt_q      <= '0;
      out_bf16_q <= '0;
      out_exc_q  <= '0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      sig_q      <= sig_d;
      cnt_q      <= cnt_d;
      out_bf16_q <= out_bf16_d;
      out_exc_q  <= out_exc_d;
    end
  end
endmodule
